// File: rtl/engine_fabric_pkg.sv
// Shared types and the round-robin pick helper for the engine channel fabric.
package engine_fabric_pkg;

  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  localparam int PKG_PC_WIDTH   = 8;
  localparam int PKG_CC_ID_BITS = 1;

  typedef struct packed {
    logic [PKG_PC_WIDTH-1:0]   pc;
    logic [PKG_CC_ID_BITS-1:0] cc_id;
  } pc_entry_t;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] at or after ptr, wrapping past n-1 back to 0.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!r.valid && req[idx]) begin
          r.valid = 1'b1;
          r.idx   = idx[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/engine_channel_fabric_rr_arbiter.sv
// Combinational round-robin arbiter; the caller owns and advances the pointer.
module rr_arbiter
  import engine_fabric_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                   req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic                           grant_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
  output logic [N-1:0]                   grant_onehot
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  rr_pick_t pick;

  always_comb begin
    pick         = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr), N);
    grant_valid  = pick.valid;
    grant_idx    = pick.idx[IW-1:0];
    grant_onehot = '0;
    if (pick.valid) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/engine_channel_fabric.sv
// One upstream PC channel fanned out to ENGINE_COUNT engines and merged back.
// Optional counters: define ENGINE_CHANNEL_FABRIC_PERF_EN.
module engine_channel_fabric
  import engine_fabric_pkg::*;
#(
  parameter int PC_WIDTH            = 8,
  parameter int CC_ID_BITS          = 1,
  parameter int LATENCY_COUNT_WIDTH = 8,
  parameter int ENGINE_COUNT        = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  input  logic [PC_WIDTH+CC_ID_BITS-1:0]                in_data,
  input  logic [LATENCY_COUNT_WIDTH-1:0]                in_latency,
  output logic                                          in_ready,
  output logic [ENGINE_COUNT-1:0]                       eng_in_valid,
  output logic [ENGINE_COUNT*(PC_WIDTH+CC_ID_BITS)-1:0] eng_in_data,
  output logic [ENGINE_COUNT*LATENCY_COUNT_WIDTH-1:0]   eng_in_latency,
  input  logic [ENGINE_COUNT-1:0]                       eng_in_ready,
  input  logic [ENGINE_COUNT-1:0]                       eng_out_valid,
  input  logic [ENGINE_COUNT*(PC_WIDTH+CC_ID_BITS)-1:0] eng_out_data,
  output logic [ENGINE_COUNT-1:0]                       eng_out_ready,
  input  logic [ENGINE_COUNT-1:0]                       eng_running,
  output logic                                          out_valid,
  output logic [PC_WIDTH+CC_ID_BITS-1:0]                out_data,
  output logic [LATENCY_COUNT_WIDTH-1:0]                out_latency,
  input  logic                                          out_ready,
`ifdef ENGINE_CHANNEL_FABRIC_PERF_EN
  output logic [31:0]                                   perf_dispatched [ENGINE_COUNT],
  output logic [31:0]                                   perf_disp_stall,
  output logic [31:0]                                   perf_out_stall,
`endif
  output logic                                          idle
);

  localparam int W        = PC_WIDTH + CC_ID_BITS;
  localparam int ENG_BITS = (ENGINE_COUNT > 1) ? $clog2(ENGINE_COUNT) : 1;
  localparam logic [ENG_BITS-1:0] LAST_ENG = ENG_BITS'(ENGINE_COUNT - 1);

  logic                           dr_valid_q, dr_valid_d;
  logic [W-1:0]                   dr_data_q, dr_data_d;
  logic [LATENCY_COUNT_WIDTH-1:0] dr_lat_q, dr_lat_d;
  logic [ENG_BITS-1:0]            disp_ptr_q, disp_ptr_d;
  logic                           mr_valid_q, mr_valid_d;
  logic [W-1:0]                   mr_data_q, mr_data_d;
  logic [LATENCY_COUNT_WIDTH-1:0] mr_lat_q, mr_lat_d;
  logic [ENG_BITS-1:0]            merge_ptr_q, merge_ptr_d;

  logic                    d_gv, m_gv;
  logic [ENG_BITS-1:0]     d_gi, m_gi;
  logic [ENGINE_COUNT-1:0] d_oh, m_oh;
  logic                    dispatch_fire, mr_load;

  function automatic logic [ENG_BITS-1:0] next_ptr(input logic [ENG_BITS-1:0] g);
    return (g == LAST_ENG) ? '0 : g + 1'b1;
  endfunction

  rr_arbiter #(.N(ENGINE_COUNT)) u_disp_arb (
    .req(eng_in_ready), .ptr(disp_ptr_q),
    .grant_valid(d_gv), .grant_idx(d_gi), .grant_onehot(d_oh)
  );

  rr_arbiter #(.N(ENGINE_COUNT)) u_merge_arb (
    .req(eng_out_valid), .ptr(merge_ptr_q),
    .grant_valid(m_gv), .grant_idx(m_gi), .grant_onehot(m_oh)
  );

  always_comb begin
    dispatch_fire = dr_valid_q && d_gv;
    in_ready      = !dr_valid_q || dispatch_fire;
    dr_valid_d    = dr_valid_q;
    dr_data_d     = dr_data_q;
    dr_lat_d      = dr_lat_q;
    disp_ptr_d    = disp_ptr_q;
    if (dispatch_fire) begin
      dr_valid_d = 1'b0;
      disp_ptr_d = next_ptr(d_gi);
    end
    if (in_valid && in_ready) begin
      dr_valid_d = 1'b1;
      dr_data_d  = in_data;
      dr_lat_d   = in_latency;
    end

    mr_load     = (!mr_valid_q || out_ready) && m_gv;
    mr_valid_d  = mr_valid_q;
    mr_data_d   = mr_data_q;
    mr_lat_d    = mr_lat_q;
    merge_ptr_d = merge_ptr_q;
    if (mr_valid_q && out_ready) mr_valid_d = 1'b0;
    else if (mr_valid_q && (mr_lat_q != '1)) mr_lat_d = mr_lat_q + 1'b1;
    if (mr_load) begin
      mr_valid_d  = 1'b1;
      mr_data_d   = eng_out_data[int'(m_gi)*W +: W];
      mr_lat_d    = '0;
      merge_ptr_d = next_ptr(m_gi);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_valid_q  <= 1'b0;
      dr_data_q   <= '0;
      dr_lat_q    <= '0;
      disp_ptr_q  <= '0;
      mr_valid_q  <= 1'b0;
      mr_data_q   <= '0;
      mr_lat_q    <= '0;
      merge_ptr_q <= '0;
    end else begin
      dr_valid_q  <= dr_valid_d;
      dr_data_q   <= dr_data_d;
      dr_lat_q    <= dr_lat_d;
      disp_ptr_q  <= disp_ptr_d;
      mr_valid_q  <= mr_valid_d;
      mr_data_q   <= mr_data_d;
      mr_lat_q    <= mr_lat_d;
      merge_ptr_q <= merge_ptr_d;
    end
  end

  // Holding reset keeps engines from seeing a merge accept they could act on.
  assign eng_out_ready  = (mr_load && !rst) ? m_oh : '0;
  assign eng_in_valid   = dr_valid_q ? d_oh : '0;
  assign eng_in_data    = {ENGINE_COUNT{dr_data_q}};
  assign eng_in_latency = {ENGINE_COUNT{dr_lat_q}};
  assign out_valid      = mr_valid_q;
  assign out_data       = mr_data_q;
  assign out_latency    = mr_lat_q;
  assign idle           = !dr_valid_q && !mr_valid_q && !(|eng_running);

`ifdef ENGINE_CHANNEL_FABRIC_PERF_EN
  logic [31:0] perf_disp_q [ENGINE_COUNT];
  logic [31:0] perf_dstall_q, perf_ostall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENGINE_COUNT; i++) perf_disp_q[i] <= '0;
      perf_dstall_q <= '0;
      perf_ostall_q <= '0;
    end else begin
      for (int i = 0; i < ENGINE_COUNT; i++)
        if (dispatch_fire && d_oh[i]) perf_disp_q[i] <= perf_disp_q[i] + 1'b1;
      if (dr_valid_q && !d_gv) perf_dstall_q <= perf_dstall_q + 1'b1;
      if (mr_valid_q && !out_ready) perf_ostall_q <= perf_ostall_q + 1'b1;
    end
  end

  assign perf_dispatched = perf_disp_q;
  assign perf_disp_stall = perf_dstall_q;
  assign perf_out_stall  = perf_ostall_q;
`endif

endmodule

// File: tb/tb_engine_channel_fabric.sv
// Directed bench for engine_channel_fabric: a per-cycle vector table plus
// hand-written stall, saturation and reset sequences.
module tb_engine_channel_fabric;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [8:0]  in_data;
  logic [7:0]  in_latency;
  logic        in_ready;
  logic [3:0]  eng_in_valid;
  logic [35:0] eng_in_data;
  logic [31:0] eng_in_latency;
  logic [3:0]  eng_in_ready;
  logic [3:0]  eng_out_valid;
  logic [35:0] eng_out_data;
  logic [3:0]  eng_out_ready;
  logic [3:0]  eng_running;
  logic        out_valid;
  logic [8:0]  out_data;
  logic [7:0]  out_latency;
  logic        out_ready;
  logic        idle;
`ifdef ENGINE_CHANNEL_FABRIC_PERF_EN
  logic [31:0] perf_dispatched [4];
  logic [31:0] perf_disp_stall;
  logic [31:0] perf_out_stall;
`endif

  engine_channel_fabric dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_latency(in_latency), .in_ready(in_ready),
    .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data), .eng_in_latency(eng_in_latency),
    .eng_in_ready(eng_in_ready),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data), .eng_out_ready(eng_out_ready),
    .eng_running(eng_running),
    .out_valid(out_valid), .out_data(out_data), .out_latency(out_latency), .out_ready(out_ready),
`ifdef ENGINE_CHANNEL_FABRIC_PERF_EN
    .perf_dispatched(perf_dispatched), .perf_disp_stall(perf_disp_stall),
    .perf_out_stall(perf_out_stall),
`endif
    .idle(idle)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       iv;
    logic [8:0] id;
    logic [3:0] eir;
    logic [3:0] eov;
    logic       ordy;
    logic       x_ir;
    logic [3:0] x_eiv;
    logic [8:0] x_eid;
    logic [3:0] x_eor;
    logic       x_ov;
    logic [8:0] x_od;
    logic       x_idle;
  } vec_t;

  vec_t vt [17];

  function automatic vec_t mk(logic iv, logic [8:0] id, logic [3:0] eir, logic [3:0] eov,
                              logic ordy, logic x_ir, logic [3:0] x_eiv, logic [8:0] x_eid,
                              logic [3:0] x_eor, logic x_ov, logic [8:0] x_od, logic x_idle);
    vec_t v;
    v.iv = iv; v.id = id; v.eir = eir; v.eov = eov; v.ordy = ordy;
    v.x_ir = x_ir; v.x_eiv = x_eiv; v.x_eid = x_eid; v.x_eor = x_eor;
    v.x_ov = x_ov; v.x_od = x_od; v.x_idle = x_idle;
    return v;
  endfunction

  function automatic logic [7:0] lat_of(input logic [8:0] d);
    return d[7:0] ^ 8'h5A;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic drive(input logic iv, input logic [8:0] id, input logic [3:0] eir,
                       input logic [3:0] eov, input logic ordy);
    in_valid      = iv;
    in_data       = id;
    in_latency    = lat_of(id);
    eng_in_ready  = eir;
    eng_out_valid = eov;
    out_ready     = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // iv  id      eir    eov    ordy x_ir x_eiv  x_eid   x_eor  x_ov x_od    x_idle
    vt[0]  = mk(1, 9'h101, 4'hF, 4'h0, 1, 1, 4'h0, 9'h000, 4'h0, 0, 9'h000, 1);
    vt[1]  = mk(1, 9'h102, 4'hF, 4'h0, 1, 1, 4'h1, 9'h101, 4'h0, 0, 9'h000, 0);
    vt[2]  = mk(1, 9'h103, 4'hF, 4'h0, 1, 1, 4'h2, 9'h102, 4'h0, 0, 9'h000, 0);
    vt[3]  = mk(1, 9'h104, 4'hF, 4'h0, 1, 1, 4'h4, 9'h103, 4'h0, 0, 9'h000, 0);
    vt[4]  = mk(0, 9'h000, 4'hF, 4'h0, 1, 1, 4'h8, 9'h104, 4'h0, 0, 9'h000, 0);
    vt[5]  = mk(0, 9'h000, 4'hF, 4'h0, 1, 1, 4'h0, 9'h000, 4'h0, 0, 9'h000, 1);
    vt[6]  = mk(1, 9'h0B0, 4'h4, 4'h0, 1, 1, 4'h0, 9'h000, 4'h0, 0, 9'h000, 1);
    vt[7]  = mk(1, 9'h0B1, 4'h4, 4'h0, 1, 1, 4'h4, 9'h0B0, 4'h0, 0, 9'h000, 0);
    vt[8]  = mk(1, 9'h0B2, 4'h4, 4'h0, 1, 1, 4'h4, 9'h0B1, 4'h0, 0, 9'h000, 0);
    vt[9]  = mk(0, 9'h000, 4'h4, 4'h0, 1, 1, 4'h4, 9'h0B2, 4'h0, 0, 9'h000, 0);
    vt[10] = mk(0, 9'h000, 4'h4, 4'h0, 1, 1, 4'h0, 9'h000, 4'h0, 0, 9'h000, 1);
    vt[11] = mk(0, 9'h000, 4'hF, 4'hF, 1, 1, 4'h0, 9'h000, 4'h1, 0, 9'h000, 1);
    vt[12] = mk(0, 9'h000, 4'hF, 4'hF, 1, 1, 4'h0, 9'h000, 4'h2, 1, 9'h011, 0);
    vt[13] = mk(0, 9'h000, 4'hF, 4'hF, 1, 1, 4'h0, 9'h000, 4'h4, 1, 9'h022, 0);
    vt[14] = mk(0, 9'h000, 4'hF, 4'hF, 1, 1, 4'h0, 9'h000, 4'h8, 1, 9'h033, 0);
    vt[15] = mk(0, 9'h000, 4'hF, 4'h0, 1, 1, 4'h0, 9'h000, 4'h0, 1, 9'h044, 0);
    vt[16] = mk(0, 9'h000, 4'hF, 4'h0, 1, 1, 4'h0, 9'h000, 4'h0, 0, 9'h000, 1);

    eng_out_data = {9'h044, 9'h033, 9'h022, 9'h011};
    eng_running  = 4'h0;
    drive(0, 9'h000, 4'h0, 4'h0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst eng_in_valid", eng_in_valid, 0);
    chk("rst eng_out_ready", eng_out_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_latency", out_latency, 0);
    chk("rst idle", idle, 1);
    tick();

    // dispatch order, single-engine target, round-robin merge
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].iv, vt[i].id, vt[i].eir, vt[i].eov, vt[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, vt[i].x_ir);
      chk($sformatf("v%0d eng_in_valid", i), eng_in_valid, vt[i].x_eiv);
      if (vt[i].x_eiv != 4'h0) begin
        chk($sformatf("v%0d eng_in_data", i), eng_in_data, {4{vt[i].x_eid}});
        chk($sformatf("v%0d eng_in_latency", i), eng_in_latency, {4{lat_of(vt[i].x_eid)}});
      end
      chk($sformatf("v%0d eng_out_ready", i), eng_out_ready, vt[i].x_eor);
      chk($sformatf("v%0d out_valid", i), out_valid, vt[i].x_ov);
      if (vt[i].x_ov) begin
        chk($sformatf("v%0d out_data", i), out_data, vt[i].x_od);
        chk($sformatf("v%0d out_latency", i), out_latency, 0);
      end
      chk($sformatf("v%0d idle", i), idle, vt[i].x_idle);
      tick();
    end

    // all engines stalled with DR full; dispatch pointer sits at 3
    drive(1, 9'h1C0, 4'h0, 4'h0, 1);
    #1;
    chk("stall load in_ready", in_ready, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 9'h1C1, 4'h0, 4'h0, 1);
      #1;
      chk($sformatf("stall%0d in_ready", i), in_ready, 0);
      chk($sformatf("stall%0d eng_in_valid", i), eng_in_valid, 0);
      chk($sformatf("stall%0d eng_in_data", i), eng_in_data, {4{9'h1C0}});
      tick();
    end
    drive(1, 9'h1C1, 4'hF, 4'h0, 1);
    #1;
    chk("release eng_in_valid", eng_in_valid, 4'h8);
    chk("release eng_in_data", eng_in_data, {4{9'h1C0}});
    chk("release in_ready", in_ready, 1);
    tick();
    drive(0, 9'h000, 4'hF, 4'h0, 1);
    #1;
    chk("follow eng_in_valid", eng_in_valid, 4'h1);
    chk("follow eng_in_data", eng_in_data, {4{9'h1C1}});
    tick();
    chk("drained eng_in_valid", eng_in_valid, 0);

    // out_latency saturation while downstream stalls; merge pointer at 0
    drive(0, 9'h000, 4'hF, 4'h1, 0);
    #1;
    chk("sat load eng_out_ready", eng_out_ready, 4'h1);
    tick();
    drive(0, 9'h000, 4'hF, 4'h2, 0);
    #1;
    chk("sat held eng_out_ready", eng_out_ready, 0);
    chk("sat lat start", out_latency, 0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 10) chk("sat lat 10", out_latency, 10);
    end
    chk("sat lat 255", out_latency, 8'hFF);
    chk("sat out_valid", out_valid, 1);
    chk("sat out_data", out_data, 9'h011);
    drive(0, 9'h000, 4'hF, 4'h0, 1);
    tick();
    chk("sat drain out_valid", out_valid, 0);

    // reset with DR and MR both full; pointers had moved to 1 and 1
    drive(1, 9'h1E0, 4'h0, 4'h2, 0);
    tick();
    chk("prerst out_valid", out_valid, 1);
    chk("prerst out_data", out_data, 9'h022);
    chk("prerst in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("midrst in_ready", in_ready, 1);
    chk("midrst eng_in_valid", eng_in_valid, 0);
    chk("midrst eng_out_ready", eng_out_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_data", out_data, 0);
    chk("midrst out_latency", out_latency, 0);
    chk("midrst idle", idle, 1);
`ifdef ENGINE_CHANNEL_FABRIC_PERF_EN
    for (int i = 0; i < 4; i++) chk($sformatf("midrst perf_disp%0d", i), perf_dispatched[i], 0);
    chk("midrst perf_disp_stall", perf_disp_stall, 0);
    chk("midrst perf_out_stall", perf_out_stall, 0);
`endif
    rst = 1'b0;
    drive(1, 9'h1E1, 4'hF, 4'hF, 1);
    #1;
    chk("postrst eng_out_ready", eng_out_ready, 4'h1);
    chk("postrst eng_in_valid", eng_in_valid, 0);
    tick();
    chk("postrst dispatch", eng_in_valid, 4'h1);
    chk("postrst dispatch data", eng_in_data, {4{9'h1E1}});
    chk("postrst out_data", out_data, 9'h011);
    drive(0, 9'h000, 4'hF, 4'h0, 1);
    tick();
    eng_running = 4'h2;
    #1;
    chk("running idle", idle, 0);
    eng_running = 4'h0;
    #1;
    chk("quiet idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/engine_channel_fabric.md
# engine_channel_fabric

Parametrised successor to the single-engine interfaced wrapper. It connects one upstream PC channel to `ENGINE_COUNT` vectorial engines and merges their output PC channels back into one downstream channel. Upstream entries are dispatched round-robin to ready engines, and engine outputs are merged round-robin. Both directions pass through a one-entry registered stage, so no combinational path runs from upstream to downstream. It sits between the coprocessor's channel ring and a bank of engines, and replaces per-engine wiring at the top level.

## Interface
Parameters:
- `PC_WIDTH`, 8, program-counter width.
- `CC_ID_BITS`, 1, character-context id width.
- `LATENCY_COUNT_WIDTH`, 8, latency field width.
- `ENGINE_COUNT`, 4, number of engines (≥1).
- `ENG_BITS`, `$clog2(ENGINE_COUNT)` (min 1), engine index width; derived, not overridden.

Ports (W = `PC_WIDTH+CC_ID_BITS`):
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream entry valid.
- `in_data` in W: `{pc, cc_id}`.
- `in_latency` in `LATENCY_COUNT_WIDTH`: upstream latency tag.
- `in_ready` out 1: upstream accept.
- `eng_in_valid` out `ENGINE_COUNT`: per-engine dispatch valid.
- `eng_in_data` out `ENGINE_COUNT*W`: broadcast dispatch data (same value on all slices).
- `eng_in_latency` out `ENGINE_COUNT*LATENCY_COUNT_WIDTH`: broadcast latency.
- `eng_in_ready` in `ENGINE_COUNT`: per-engine accept.
- `eng_out_valid` in `ENGINE_COUNT`: per-engine output valid.
- `eng_out_data` in `ENGINE_COUNT*W`: per-engine output data.
- `eng_out_ready` out `ENGINE_COUNT`: per-engine output accept (one-hot or zero).
- `eng_running` in `ENGINE_COUNT`: engine busy flags.
- `out_valid` out 1: merged output valid.
- `out_data` out W: merged output data.
- `out_latency` out `LATENCY_COUNT_WIDTH`: wait cycles of the held output entry.
- `out_ready` in 1: downstream accept.
- `idle` out 1: fabric empty and no engine running.

## Operation
- Dispatch register (DR):
  - `in_ready = !dr_valid || dispatch_fire`.
  - When `in_valid && in_ready`, DR loads data and latency.
  - `dispatch_fire` means DR is valid and at least one engine is ready.
- Dispatch grant:
  - Search `eng_in_ready` starting at `disp_ptr` and wrapping; take the first ready index g.
  - `eng_in_valid = onehot(g)` when DR is valid, else 0.
  - On fire, `disp_ptr <= (g+1) mod ENGINE_COUNT`.
- Merge register (MR):
  - `mr_load = (!mr_valid || out_ready)` and at least one `eng_out_valid` is set.
  - Search from `merge_ptr` and wrap; grant index m.
  - `eng_out_ready = onehot(m)` only when `mr_load`.
  - MR captures `eng_out_data[m]`; `merge_ptr <= (m+1) mod ENGINE_COUNT`.
- `out_latency`:
  - Cleared to 0 on load.
  - Increments by 1 each cycle `out_valid && !out_ready`.
  - Saturates at all-ones.
- `idle = !dr_valid && !mr_valid && !(|eng_running)`.
- Simultaneous load and drain on either register: the register reloads in the same cycle with no bubble, giving full throughput of one entry per cycle.
- `ENGINE_COUNT==1`: pointers stay at 0 and grant is engine 0 whenever it is ready.

## Timing
- Reset values:
  - `dr_valid=0`, `mr_valid=0`, `disp_ptr=0`, `merge_ptr=0`.
  - `in_ready=1`.
  - `eng_in_valid=0`, `eng_out_ready=0`.
  - `out_valid=0`, `out_data=0`, `out_latency=0`.
  - `idle=1` when `eng_running` is 0.
- Latency:
  - Upstream to engine: 1 cycle (DR).
  - Engine to downstream: 1 cycle (MR).
- Handshake: valid/ready.
  - Once asserted, `out_valid` and `out_data` hold until `out_ready`.
  - `eng_in_valid` may move between engines while DR waits; DR contents do not change.
- All engines not ready: DR holds and `in_ready=0`.
- Reset mid-operation: in-flight DR and MR entries are discarded; no partial handshake follows reset.

## Configuration
`ENGINE_CHANNEL_FABRIC_PERF_EN`: when defined, the block adds three outputs.
- `perf_dispatched[ENGINE_COUNT]`, 32-bit each: counts dispatch fires per engine.
- `perf_disp_stall`, 32-bit: counts cycles with `dr_valid` set and no engine ready.
- `perf_out_stall`, 32-bit: counts cycles with `out_valid && !out_ready`.

Counter rules:
- All counters wrap.
- All counters clear on `rst`.

When the macro is not defined, these ports and counters are absent and the block's function is otherwise identical.

## Structure
- Shared package `engine_fabric_pkg` holds:
  - `function rr_pick(req, ptr)`, which returns a valid flag and an index.
  - `typedef` for the `{pc, cc_id}` entry struct.
- One sub-module is natural: `rr_arbiter` (parameter N; inputs `req`, `ptr`; outputs `grant_valid`, `grant_idx`, `grant_onehot`).
  - Instantiated twice, once for dispatch and once for merge.
  - Combinational; the block owns the pointers.

## Test plan
- Reset, then 4 back-to-back entries with all `eng_in_ready=1` and `ENGINE_COUNT=4` -> entries land on engines 0,1,2,3 in order, one per cycle after 1-cycle latency.
- `eng_in_ready=4'b0100` constant, 3 entries -> all dispatch to engine 2; `in_ready` never drops.
- `eng_in_ready=0` for 5 cycles with DR full -> `in_ready=0` and DR is stable; on release, the entry dispatches next cycle.
- All four `eng_out_valid` high, data `0x11,0x22,0x33,0x44`, with `out_ready=1` -> output sequence `0x11,0x22,0x33,0x44` and `eng_out_ready` one-hot rotating.
- `out_ready=0` for 300 cycles with `LATENCY_COUNT_WIDTH=8` -> `out_latency` saturates at 255; `out_data` is stable.
- Assert `rst` with DR and MR both full -> next cycle all reset values hold; with the PERF macro defined, counters read 0.
